branch_sequencer: RTL and testbench

Multi-cycle branch resolution controller for the monociclo datapath. On a start pulse it latches a branch's operands, requests the shared ALU through a request/grant port, and issues the comparison operation for the branch's func3. It then evaluates the ALU result into a taken flag and reports the next PC with a one-cycle done pulse. It lets the branch-compare logic share the main ALU instead of using a dedicated comparator.

---
 rtl/branch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Multi-cycle branch resolution controller. Latches a branch on start_i,
//   borrows the shared ALU through a req/gnt handshake to do the compare,
//   turns the ALU result into a taken flag and reports the next PC with a
//   single-cycle done_o pulse.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              begin a branch (only honoured in IDLE)
//   func3_i              RV32I branch func3
//   rs1_i, rs2_i         compare operands
//   pc_i, imm_i          branch PC and sign-extended offset
//   alu_gnt_i            shared ALU granted; alu_result_i valid same cycle
//   alu_result_i         shared ALU result
//   alu_req_o            shared ALU request (high for the whole REQ phase)
//   alu_a_o, alu_b_o     latched operands, zero while not requesting
//   alu_op_o             00 SUB, 01 SLT, 10 SLTU
//   busy_o               not IDLE
//   done_o               one-cycle completion pulse
//   taken_o, next_pc_o   resolved branch, held until the next result
//   error_o              illegal func3 or grant timeout
module branch_sequencer #(
    parameter int GNT_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic        alu_gnt_i,
    input  logic [31:0] alu_result_i,
    output logic        alu_req_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [1:0]  alu_op_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        taken_o,
    output logic [31:0] next_pc_o,
    output logic        error_o
);

    localparam int CW = (GNT_TIMEOUT > 0) ? $clog2(GNT_TIMEOUT + 1) : 1;
    // Counter value seen during the last allowed ungranted REQ cycle.
    localparam logic [CW-1:0] TO_LAST = (GNT_TIMEOUT > 0) ? CW'(GNT_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    func3_q, func3_d;
    logic [31:0]   rs1_q, rs1_d;
    logic [31:0]   rs2_q, rs2_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   imm_q, imm_d;
    logic [31:0]   res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          taken_q, taken_d;
    logic [31:0]   npc_q, npc_d;
    logic          error_q, error_d;

    logic          illegal_start;
    logic          zero;
    logic          take;
    logic [1:0]    op;

    assign illegal_start = (func3_i == 3'b010) || (func3_i == 3'b011);
    assign zero          = (res_q == 32'd0);
    // beq/bge/bgeu take on zero, bne/blt/bltu take on non-zero;
    // func3[0]^func3[2] is set exactly for the second group.
    assign take          = zero ^ (func3_q[0] ^ func3_q[2]);
    assign op            = func3_q[2] ? (func3_q[1] ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d = state_q;
        func3_d = func3_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        npc_d   = npc_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    func3_d = func3_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    pc_d    = pc_i;
                    imm_d   = imm_i;
                    cnt_d   = '0;
                    if (illegal_start) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                        taken_d = 1'b0;
                        npc_d   = pc_i + 32'd4;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (alu_gnt_i) begin
                    // A grant in the last allowed cycle beats the timeout.
                    res_d   = alu_result_i;
                    state_d = S_EVAL;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if ((GNT_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                        taken_d = 1'b0;
                        npc_d   = pc_q + 32'd4;
                    end
                end
            end
            S_EVAL: begin
                taken_d = take;
                error_d = 1'b0;
                npc_d   = take ? (pc_q + imm_q) : (pc_q + 32'd4);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            func3_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            npc_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            func3_q <= func3_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            npc_q   <= npc_d;
            error_q <= error_d;
        end
    end

    assign alu_req_o = (state_q == S_REQ);
    assign alu_a_o   = alu_req_o ? rs1_q : 32'd0;
    assign alu_b_o   = alu_req_o ? rs2_q : 32'd0;
    assign alu_op_o  = alu_req_o ? op : 2'b00;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign taken_o   = taken_q;
    assign next_pc_o = npc_q;
    assign error_o   = error_q;

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

    localparam int GTO = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  func3_i = '0;
    logic [31:0] rs1_i = '0, rs2_i = '0, pc_i = '0, imm_i = '0;
    logic        alu_gnt_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic        alu_req_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [1:0]  alu_op_o;
    logic        busy_o, done_o, taken_o, error_o;
    logic [31:0] next_pc_o;

    branch_sequencer #(.GNT_TIMEOUT(GTO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .func3_i(func3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imm_i(imm_i),
        .alu_gnt_i(alu_gnt_i), .alu_result_i(alu_result_i),
        .alu_req_o(alu_req_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_op_o(alu_op_o), .busy_o(busy_o), .done_o(done_o),
        .taken_o(taken_o), .next_pc_o(next_pc_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        taken;
        logic [31:0] npc;
        logic        err;
        int          lat;
        int          scyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   req_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Output monitor: counts request cycles and scores every done pulse.
    always @(negedge clk_i) begin
        if (alu_req_o) req_cnt++;
        if (done_o) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done_o}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("taken", {31'd0, taken_o}, {31'd0, mon_e.taken});
                chk("next_pc", next_pc_o, mon_e.npc);
                chk("error", {31'd0, error_o}, {31'd0, mon_e.err});
                chk("latency", cyc - mon_e.scyc, mon_e.lat);
            end
        end
    end

    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2])      return a - b;
        else if (!f3[1]) return {31'd0, $signed(a) < $signed(b)};
        else             return {31'd0, a < b};
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return !($signed(a) < $signed(b));
            3'b110:  return a < b;
            default: return !(a < b);
        endcase
    endfunction

    // d: number of ungranted REQ cycles before the grant (negative = never).
    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input int d,
                       input bit busy_start);
        bit          legal;
        bit          tmo;
        logic [1:0]  xop;
        logic [31:0] res;
        exp_t        e;
        int          rb;
        legal = !(f3 == 3'b010 || f3 == 3'b011);
        tmo   = legal && (d < 0 || d >= GTO);
        xop   = f3[2] ? (f3[1] ? 2'b10 : 2'b01) : 2'b00;
        res   = alu_model(f3, a, b);
        if (!legal || tmo) begin
            e.taken = 1'b0; e.npc = pc + 32'd4; e.err = 1'b1;
            e.lat   = legal ? GTO + 1 : 1;
        end else begin
            e.taken = br_taken(f3, a, b);
            e.npc   = e.taken ? pc + imm : pc + 32'd4;
            e.err   = 1'b0;
            e.lat   = 3 + d;
        end
        @(posedge clk_i); #1;
        start_i = 1'b1; func3_i = f3; rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm;
        rb = req_cnt;
        e.scyc = cyc;
        sb.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        func3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom; pc_i = $urandom; imm_i = $urandom;
        if (legal) begin
            for (int k = 0; k < GTO; k++) begin
                start_i      = busy_start && (k == 0);
                alu_gnt_i    = (k == d);
                alu_result_i = (k == d) ? res : $urandom;
                #1;
                if (k == 0) begin
                    chk("req", {31'd0, alu_req_o}, 32'd1);
                    chk("alu_a", alu_a_o, a);
                    chk("alu_b", alu_b_o, b);
                    chk("alu_op", {30'd0, alu_op_o}, {30'd0, xop});
                end
                @(posedge clk_i); #1;
                if (k == d) break;
            end
            start_i = 1'b0; alu_gnt_i = 1'b0; alu_result_i = $urandom;
        end
        for (int w = 0; w < 12 && sb.size() != 0; w++) @(negedge clk_i);
        if (sb.size() != 0) begin
            chk("done_wait", sb.size(), 0);
            sb.delete();
        end
        chk("req_cycles", req_cnt - rb, !legal ? 0 : (tmo ? GTO : d + 1));
        chk("hold_npc", next_pc_o, e.npc);
    endtask

    initial begin
        logic [2:0] fl[6];
        logic [2:0] f;
        logic [31:0] a, b;
        fl = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_req", {31'd0, alu_req_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_npc", next_pc_o, 32'd0);
        chk("rst_taken_err", {30'd0, taken_o, error_o}, 32'd0);
        chk("rst_alu", alu_a_o | alu_b_o | {30'd0, alu_op_o}, 32'd0);

        run(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 0, 0);              // beq taken
        run(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 0);      // blt taken
        run(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 0);      // bge not taken
        run(3'b111, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, 32'h20, 0, 0); // bgeu wrap
        run(3'b001, 32'h7, 32'h9, 32'h300, 32'h10, 2, 1);              // grant on 3rd cycle, busy start
        run(3'b110, 32'h1, 32'h2, 32'h400, 32'h8, -1, 0);              // timeout
        run(3'b010, 32'h1, 32'h1, 32'h500, 32'h8, 0, 0);               // illegal
        run(3'b011, 32'h1, 32'h1, 32'h600, 32'h8, 0, 0);               // illegal
        for (int i = 0; i < 8; i++) begin
            f = fl[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            run(f, a, b, $urandom, $urandom, $urandom_range(0, 2), 0);
        end

        // Reset in the middle of REQ: nothing should complete.
        @(posedge clk_i); #1;
        start_i = 1'b1; func3_i = 3'b000; rs1_i = 32'h1; rs2_i = 32'h1; pc_i = 32'h700; imm_i = 32'h4;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("mid_req", {31'd0, alu_req_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mrst_busy", {31'd0, busy_o}, 32'd0);
        chk("mrst_req", {31'd0, alu_req_o}, 32'd0);
        chk("mrst_alu", alu_a_o | alu_b_o | {30'd0, alu_op_o}, 32'd0);
        chk("mrst_npc", next_pc_o, 32'd0);
        chk("mrst_flags", {29'd0, done_o, taken_o, error_o}, 32'd0);
        repeat (6) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
